// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - arbitrates requester reads/writes onto NUM_CHANNELS memory channels
// Write path (WRITE_WAIT/WRITE_RELAY) is built only when MEM_CONTROLLER_WRITE_EN is defined.
module mem_controller #(
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]  mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]  mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
  output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);
  localparam int OW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] READ_WAIT  = 3'd1;
  localparam logic [2:0] READ_RELAY = 3'd3;
`ifdef MEM_CONTROLLER_WRITE_EN
  localparam logic [2:0] WRITE_WAIT  = 3'd2;
  localparam logic [2:0] WRITE_RELAY = 3'd4;
`endif

  logic [2:0]               state_q [NUM_CHANNELS];
  logic [2:0]               state_d [NUM_CHANNELS];
  logic [OW-1:0]            owner_q [NUM_CHANNELS];
  logic [OW-1:0]            owner_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d, scan;
  logic                     found;
  logic [NUM_CHANNELS-1:0]  mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]     mem_read_address_q [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     mem_read_address_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] consumer_read_ready_q, consumer_read_ready_d;
  logic [DATA_BITS-1:0]     consumer_read_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     consumer_read_data_d [NUM_CONSUMERS];
`ifdef MEM_CONTROLLER_WRITE_EN
  logic [NUM_CHANNELS-1:0]  mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]     mem_write_address_q [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     mem_write_address_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     mem_write_data_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     mem_write_data_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] consumer_write_ready_q, consumer_write_ready_d;
`endif

  always_comb begin
    state_d               = state_q;
    owner_d               = owner_q;
    claimed_d             = claimed_q;
    mem_read_valid_d      = mem_read_valid_q;
    mem_read_address_d    = mem_read_address_q;
    consumer_read_ready_d = consumer_read_ready_q;
    consumer_read_data_d  = consumer_read_data_q;
`ifdef MEM_CONTROLLER_WRITE_EN
    mem_write_valid_d      = mem_write_valid_q;
    mem_write_address_d    = mem_write_address_q;
    mem_write_data_d       = mem_write_data_q;
    consumer_write_ready_d = consumer_write_ready_q;
`endif
    // scan grows as lower channels claim, so one requester is never taken twice per cycle
    scan  = claimed_q;
    found = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      found = 1'b0;
      case (state_q[ch])
        IDLE: begin
          for (int c = 0; c < NUM_CONSUMERS; c++) begin
            if (!found && !scan[c]) begin
              if (consumer_read_valid[c]) begin
                found                  = 1'b1;
                scan[c]                = 1'b1;
                claimed_d[c]           = 1'b1;
                owner_d[ch]            = OW'(c);
                mem_read_valid_d[ch]   = 1'b1;
                mem_read_address_d[ch] = consumer_read_address[c];
                state_d[ch]            = READ_WAIT;
              end
`ifdef MEM_CONTROLLER_WRITE_EN
              else if (consumer_write_valid[c]) begin
                found                   = 1'b1;
                scan[c]                 = 1'b1;
                claimed_d[c]            = 1'b1;
                owner_d[ch]             = OW'(c);
                mem_write_valid_d[ch]   = 1'b1;
                mem_write_address_d[ch] = consumer_write_address[c];
                mem_write_data_d[ch]    = consumer_write_data[c];
                state_d[ch]             = WRITE_WAIT;
              end
`endif
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready[ch]) begin
            consumer_read_data_d[owner_q[ch]]  = mem_read_data[ch];
            consumer_read_ready_d[owner_q[ch]] = 1'b1;
            mem_read_valid_d[ch]               = 1'b0;
            state_d[ch]                        = READ_RELAY;
          end
        end
        READ_RELAY: begin
          if (!consumer_read_valid[owner_q[ch]]) begin
            consumer_read_ready_d[owner_q[ch]] = 1'b0;
            claimed_d[owner_q[ch]]             = 1'b0;
            state_d[ch]                        = IDLE;
          end
        end
`ifdef MEM_CONTROLLER_WRITE_EN
        WRITE_WAIT: begin
          if (mem_write_ready[ch]) begin
            consumer_write_ready_d[owner_q[ch]] = 1'b1;
            mem_write_valid_d[ch]               = 1'b0;
            state_d[ch]                         = WRITE_RELAY;
          end
        end
        WRITE_RELAY: begin
          if (!consumer_write_valid[owner_q[ch]]) begin
            consumer_write_ready_d[owner_q[ch]] = 1'b0;
            claimed_d[owner_q[ch]]              = 1'b0;
            state_d[ch]                         = IDLE;
          end
        end
`endif
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      claimed_q             <= '0;
      mem_read_valid_q      <= '0;
      consumer_read_ready_q <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch]            <= IDLE;
        owner_q[ch]            <= '0;
        mem_read_address_q[ch] <= '0;
      end
      for (int c = 0; c < NUM_CONSUMERS; c++) consumer_read_data_q[c] <= '0;
`ifdef MEM_CONTROLLER_WRITE_EN
      mem_write_valid_q      <= '0;
      consumer_write_ready_q <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        mem_write_address_q[ch] <= '0;
        mem_write_data_q[ch]    <= '0;
      end
`endif
    end else begin
      state_q               <= state_d;
      owner_q               <= owner_d;
      claimed_q             <= claimed_d;
      mem_read_valid_q      <= mem_read_valid_d;
      mem_read_address_q    <= mem_read_address_d;
      consumer_read_ready_q <= consumer_read_ready_d;
      consumer_read_data_q  <= consumer_read_data_d;
`ifdef MEM_CONTROLLER_WRITE_EN
      mem_write_valid_q      <= mem_write_valid_d;
      mem_write_address_q    <= mem_write_address_d;
      mem_write_data_q       <= mem_write_data_d;
      consumer_write_ready_q <= consumer_write_ready_d;
`endif
    end
  end

  assign mem_read_valid      = mem_read_valid_q;
  assign mem_read_address    = mem_read_address_q;
  assign consumer_read_ready = consumer_read_ready_q;
  assign consumer_read_data  = consumer_read_data_q;

`ifdef MEM_CONTROLLER_WRITE_EN
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;
  assign consumer_write_ready = consumer_write_ready_q;
`else
  // Read-only instance: write ports exist for uniform integration but are inert.
  assign mem_write_valid      = '0;
  assign consumer_write_ready = '0;
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_wr_tie
    assign mem_write_address[g] = '0;
    assign mem_write_data[g]    = '0;
  end

  logic unused_write_in;
  always_comb begin
    unused_write_in = ^{consumer_write_valid, mem_write_ready};
    for (int c = 0; c < NUM_CONSUMERS; c++)
      unused_write_in = unused_write_in ^ (^consumer_write_address[c]) ^ (^consumer_write_data[c]);
  end
`endif
endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - scoreboard bench for mem_controller
// Write-path checks are compiled when MEM_CONTROLLER_WRITE_EN is defined.
module tb_mem_controller;
  logic        clk;
  logic        reset;
  logic [7:0]  consumer_read_valid;
  logic [7:0]  consumer_read_address [8];
  logic [7:0]  consumer_read_ready;
  logic [15:0] consumer_read_data [8];
  logic [7:0]  consumer_write_valid;
  logic [7:0]  consumer_write_address [8];
  logic [15:0] consumer_write_data [8];
  logic [7:0]  consumer_write_ready;
  logic [3:0]  mem_read_valid;
  logic [7:0]  mem_read_address [4];
  logic [3:0]  mem_read_ready;
  logic [15:0] mem_read_data [4];
  logic [3:0]  mem_write_valid;
  logic [7:0]  mem_write_address [4];
  logic [15:0] mem_write_data [4];
  logic [3:0]  mem_write_ready;

  mem_controller dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  typedef struct { int idx; logic [15:0] data; } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 0;
  int rcnt [4];
  int wcnt [4];
  int hold [8];
  int hcnt [8];
  int resp_cnt [8];
  int rdy_cyc [8];
  logic [3:0] stall     = '0;
  logic [3:0] force_rdy = '0;
  logic       beef_mode = 1'b0;
  logic [7:0] prev_rr   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // memory model: ready after lat negedges of sustained valid; read data = addr + 0x100
  initial forever begin
    @(negedge clk);
    for (int ch = 0; ch < 4; ch++) begin
      if (mem_read_valid[ch] && !stall[ch]) begin
        if (rcnt[ch] >= lat) begin
          mem_read_ready[ch] = 1'b1;
          mem_read_data[ch]  = beef_mode ? 16'hBEEF : 16'(mem_read_address[ch]) + 16'h0100;
        end else begin
          mem_read_ready[ch] = 1'b0;
          rcnt[ch]++;
        end
      end else begin
        mem_read_ready[ch] = force_rdy[ch];
        rcnt[ch] = 0;
      end
      if (mem_write_valid[ch]) begin
        if (wcnt[ch] >= lat) mem_write_ready[ch] = 1'b1;
        else begin
          mem_write_ready[ch] = 1'b0;
          wcnt[ch]++;
        end
      end else begin
        mem_write_ready[ch] = 1'b0;
        wcnt[ch] = 0;
      end
    end
  end

  // requester model: drop valid once ready seen, optionally after hold[c] extra cycles
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      if (consumer_read_ready[c] && consumer_read_valid[c]) begin
        if (hcnt[c] >= hold[c]) begin
          consumer_read_valid[c] = 1'b0;
          hcnt[c] = 0;
        end else hcnt[c]++;
      end
      if (consumer_write_ready[c] && consumer_write_valid[c]) consumer_write_valid[c] = 1'b0;
    end
  end

  // monitor: on each rising consumer_read_ready pop the matching expected entry
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      if (consumer_read_ready[c] && !prev_rr[c]) begin
        int k;
        k = -1;
        resp_cnt[c]++;
        rdy_cyc[c] = cyc;
        for (int i = 0; i < sb.size(); i++) if (k < 0 && sb[i].idx == c) k = i;
        if (k < 0) check($sformatf("unexpected_rsp[%0d]", c), 32'd1, 32'd0);
        else begin
          check($sformatf("rsp_data[%0d]", c), 32'(consumer_read_data[c]), 32'(sb[k].data));
          sb.delete(k);
        end
      end
    end
    prev_rr = consumer_read_ready;
  end

  task automatic wait_rr(input int c, input int max);
    int n;
    n = 0;
    while (!consumer_read_ready[c] && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!consumer_read_ready[c]) check($sformatf("timeout_rr[%0d]", c), 32'd0, 32'd1);
  endtask

  task automatic push(input int c, input logic [15:0] d);
    exp_t e;
    e.idx  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    int run;
    int bad;
    int seen;
    int mx;
    int mn;
    reset = 1'b1;
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    mem_read_ready       = '0;
    mem_write_ready      = '0;
    for (int c = 0; c < 8; c++) begin
      consumer_read_address[c]  = '0;
      consumer_write_address[c] = '0;
      consumer_write_data[c]    = '0;
      hold[c] = 0; hcnt[c] = 0; resp_cnt[c] = 0; rdy_cyc[c] = -1;
    end
    for (int ch = 0; ch < 4; ch++) begin
      mem_read_data[ch] = '0; rcnt[ch] = 0; wcnt[ch] = 0;
    end
    repeat (2) @(negedge clk);
    check("rst_rready", 32'(consumer_read_ready), 32'h0);
    check("rst_mrv", 32'(mem_read_valid), 32'h0);
    check("rst_mwv", 32'(mem_write_valid), 32'h0);
    check("rst_mra0", 32'(mem_read_address[0]), 32'h0);
    check("rst_rdata0", 32'(consumer_read_data[0]), 32'h0);
    reset = 1'b0;

    // single read, zero-wait memory
    @(negedge clk);
    beef_mode = 1'b1;
    lat = 0;
    push(0, 16'hBEEF);
    consumer_read_address[0] = 8'h12;
    consumer_read_valid[0]   = 1'b1;
    @(posedge clk); #1;
    check("single_mrv_c1", 32'(mem_read_valid), 32'h1);
    check("single_mra_c1", 32'(mem_read_address[0]), 32'h12);
    check("single_rr_c1", 32'(consumer_read_ready), 32'h0);
    @(posedge clk); #1;
    check("single_rr_c2", 32'(consumer_read_ready), 32'h01);
    check("single_data_c2", 32'(consumer_read_data[0]), 32'hBEEF);
    check("single_mrv_c2", 32'(mem_read_valid), 32'h0);
    @(posedge clk); #1;
    check("single_rr_c3", 32'(consumer_read_ready), 32'h0);
    check("single_claim_c3", 32'(dut.claimed_q), 32'h0);
    check("single_idle_c3", 32'(dut.state_q[0]), 32'h0);
    repeat (3) @(negedge clk);
    beef_mode = 1'b0;

    // oversubscription: 8 requesters, 4 channels, 3-cycle latency
    lat = 3;
    for (int c = 0; c < 8; c++) begin
      push(c, 16'h0120 + 16'(c));
      consumer_read_address[c] = 8'h20 + 8'(c);
      resp_cnt[c] = 0;
      rdy_cyc[c]  = -1;
    end
    consumer_read_valid = 8'hFF;
    @(posedge clk); #1;
    check("over_mrv_c1", 32'(mem_read_valid), 32'hF);
    for (int ch = 0; ch < 4; ch++)
      check($sformatf("over_mra[%0d]", ch), 32'(mem_read_address[ch]), 32'h20 + 32'(ch));
    run = 0;
    while (sb.size() != 0 && run < 300) begin
      @(negedge clk);
      run++;
    end
    check("over_drained", 32'(sb.size()), 32'h0);
    repeat (10) @(negedge clk);
    mx = -1; mn = 1 << 30;
    for (int c = 0; c < 4; c++) if (rdy_cyc[c] > mx) mx = rdy_cyc[c];
    for (int c = 4; c < 8; c++) if (rdy_cyc[c] < mn) mn = rdy_cyc[c];
    check("over_order", 32'(mx < mn && mx >= 0), 32'h1);
    for (int c = 0; c < 8; c++) check($sformatf("over_once[%0d]", c), 32'(resp_cnt[c]), 32'h1);
    check("over_claim_clear", 32'(dut.claimed_q), 32'h0);

    // slow requester holds valid 5 extra cycles after ready
    lat = 1;
    hold[0] = 5;
    push(0, 16'h0155);
    consumer_read_address[0] = 8'h55;
    consumer_read_valid[0]   = 1'b1;
    wait_rr(0, 20);
    run = 0;
    bad = 0;
    while (consumer_read_ready[0] && run < 20) begin
      if (!dut.claimed_q[0] || dut.state_q[0] != 3'd3 || mem_read_valid[0]) bad++;
      run++;
      @(negedge clk);
    end
    check("slow_ready_len", 32'(run), 32'd6);
    check("slow_held_claim", 32'(bad), 32'd0);
    check("slow_released", 32'(dut.claimed_q[0]), 32'h0);
    hold[0] = 0;
    repeat (2) @(negedge clk);

    // simultaneous read and write from requester 3: read goes first
    lat = 0;
    push(3, 16'h0133);
    consumer_read_address[3]  = 8'h33;
    consumer_write_address[3] = 8'h44;
    consumer_write_data[3]    = 16'h1234;
    consumer_read_valid[3]    = 1'b1;
    consumer_write_valid[3]   = 1'b1;
    @(posedge clk); #1;
    check("rw_mrv", 32'(mem_read_valid), 32'h1);
    check("rw_mra", 32'(mem_read_address[0]), 32'h33);
    check("rw_mwv_first", 32'(mem_write_valid), 32'h0);
    @(negedge clk);
    wait_rr(3, 20);
`ifdef MEM_CONTROLLER_WRITE_EN
    run = 0;
    seen = 0;
    while (!consumer_write_ready[3] && run < 30) begin
      if (mem_write_valid[0] && mem_write_address[0] == 8'h44 && mem_write_data[0] == 16'h1234) seen = 1;
      @(negedge clk);
      run++;
    end
    check("rw_write_issued", 32'(seen), 32'h1);
    check("rw_write_ack", 32'(consumer_write_ready[3]), 32'h1);
    repeat (3) @(negedge clk);

    // write from requester 5
    lat = 2;
    consumer_write_address[5] = 8'h40;
    consumer_write_data[5]    = 16'h00AA;
    consumer_write_valid[5]   = 1'b1;
    @(posedge clk); #1;
    check("wr_mwv", 32'(mem_write_valid), 32'h1);
    check("wr_mwa", 32'(mem_write_address[0]), 32'h40);
    check("wr_mwd", 32'(mem_write_data[0]), 32'h00AA);
    check("wr_early_ack", 32'(consumer_write_ready), 32'h0);
    @(posedge clk); #1;
    check("wr_hold_mwa", 32'(mem_write_address[0]), 32'h40);
    @(negedge clk);
    run = 0;
    while (!consumer_write_ready[5] && run < 20) begin
      @(negedge clk);
      run++;
    end
    check("wr_ack", 32'(consumer_write_ready), 32'h20);
    repeat (3) @(negedge clk);
`else
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_write_valid != 4'h0 || consumer_write_ready != 8'h0) seen = 1;
    end
    check("rw_no_write", 32'(seen), 32'h0);
    check("rw_write_pending", 32'(consumer_write_valid[3]), 32'h1);
    consumer_write_valid[3] = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // reset while channel 2 is in READ_WAIT
    stall = 4'b0111;
    for (int c = 0; c < 3; c++) consumer_read_address[c] = 8'h60 + 8'(c);
    consumer_read_valid[2:0] = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_state2", 32'(dut.state_q[2]), 32'h1);
    check("rst_mid_mrv", 32'(mem_read_valid), 32'h7);
    @(negedge clk);
    reset = 1'b1;
    consumer_read_valid = '0;
    #1;
    check("rst_mid_mrv0", 32'(mem_read_valid), 32'h0);
    check("rst_mid_mra2", 32'(mem_read_address[2]), 32'h0);
    check("rst_mid_rr", 32'(consumer_read_ready), 32'h0);
    check("rst_mid_rdata3", 32'(consumer_read_data[3]), 32'h0);
    check("rst_mid_claim", 32'(dut.claimed_q), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    stall = '0;
    force_rdy[2] = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (consumer_read_ready != 8'h0 || mem_read_valid != 4'h0) seen = 1;
    end
    force_rdy[2] = 1'b0;
    check("late_ready_ignored", 32'(seen), 32'h0);
    check("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_controller.md
# mem_controller

Arbitrates memory requests from many requesters (per-thread LSUs or per-warp fetchers) onto a fixed number of external memory channels. Sits between the cores started by the dispatcher and the GPU's `data_mem_*` / `instruction_mem_*` ports. One instance serves data memory and another serves instruction memory. Each channel runs its own request/relay state machine and owns at most one requester at a time.

## Interface
- `NUM_CONSUMERS`, default 8: number of requesters.
- `NUM_CHANNELS`, default 4: number of external memory channels.
- `ADDR_BITS`, default 8: address width.
- `DATA_BITS`, default 16: data width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `consumer_read_valid` in [NUM_CONSUMERS]: read request.
- `consumer_read_address` in ADDR_BITS x NUM_CONSUMERS: read address.
- `consumer_read_ready` out [NUM_CONSUMERS]: read response valid.
- `consumer_read_data` out DATA_BITS x NUM_CONSUMERS: read data.
- `consumer_write_valid` in [NUM_CONSUMERS]: write request.
- `consumer_write_address` in ADDR_BITS x NUM_CONSUMERS: write address.
- `consumer_write_data` in DATA_BITS x NUM_CONSUMERS: write data.
- `consumer_write_ready` out [NUM_CONSUMERS]: write acknowledge.
- `mem_read_valid` out [NUM_CHANNELS]: read request to memory.
- `mem_read_address` out ADDR_BITS x NUM_CHANNELS: read address to memory.
- `mem_read_ready` in [NUM_CHANNELS]: memory read data valid.
- `mem_read_data` in DATA_BITS x NUM_CHANNELS: memory read data.
- `mem_write_valid` out [NUM_CHANNELS]: write request to memory.
- `mem_write_address` out ADDR_BITS x NUM_CHANNELS: write address to memory.
- `mem_write_data` out DATA_BITS x NUM_CHANNELS: write data to memory.
- `mem_write_ready` in [NUM_CHANNELS]: memory write accepted.

## Operation
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- A registered `claimed[NUM_CONSUMERS]` mask marks requesters already owned by a channel. Each channel stores its owner index.
- **IDLE:** the channel scans for the lowest-index requester with valid set and no claim.
  - Channels are evaluated in ascending index within one cycle, using a combinationally updated mask, so no requester is taken twice in a cycle.
  - Read has priority over write when both valids of one requester are high.
  - On a read claim: latch the address, assert `mem_read_valid`, go to READ_WAIT.
  - On a write claim: latch address and data, assert `mem_write_valid`, go to WRITE_WAIT.
  - Set the owner's claim bit.
- **READ_WAIT:** hold valid and address until `mem_read_ready`. On that edge:
  - latch `mem_read_data` into the owner's `consumer_read_data`;
  - deassert `mem_read_valid`;
  - assert the owner's `consumer_read_ready`;
  - go to READ_RELAY.
- **WRITE_WAIT:** same as READ_WAIT, using `mem_write_ready`; assert `consumer_write_ready` and go to WRITE_RELAY.
- **READ_RELAY / WRITE_RELAY:** hold the consumer ready until the owner's matching valid is low. On that edge:
  - deassert ready;
  - clear the claim bit;
  - return to IDLE.
- A requester must hold valid and address stable until it sees ready, then drop valid. Address or data changes after the claim are ignored.
- `consumer_read_data` holds its last value until overwritten.
- Ready inputs arriving while a channel is in IDLE or RELAY are ignored.

## Timing
- Reset (async) forces:
  - all FSMs to IDLE;
  - `claimed` to 0;
  - every valid and ready output to 0;
  - every address and data output to 0.
- Memory responses in flight at reset are discarded.
- Consumer valid high in cycle 0 gives `mem_*_valid` high from cycle 1.
- Memory ready sampled at edge k gives consumer ready high from cycle k+1.
- Consumer valid low at edge j gives consumer ready low, and the channel free, from cycle j+1. The freed channel can claim again at edge j+1.
- Minimum round trip with zero-wait memory: consumer ready in cycle 2.
- When requesters outnumber channels, the extras wait with no timeout. Fairness is lowest-index-first; starvation is accepted because cores issue in lockstep.
- No combinational path exists from any input to any output. All outputs are registered.

## Configuration
- `MEM_CONTROLLER_WRITE_EN` defined: the write path, including the WRITE_WAIT and WRITE_RELAY states, is built.
- Undefined (instruction-memory instance), ports remain for uniform integration:
  - `mem_write_valid`, `mem_write_address`, `mem_write_data` and `consumer_write_ready` are tied to 0;
  - `consumer_write_valid` is ignored;
  - the FSM has only IDLE, READ_WAIT and READ_RELAY.

## Test plan
- **Single read:** requester 0 reads 0x12; memory returns 0xBEEF with 0 wait. Required: `mem_read_valid[0]` high in cycle 1; `consumer_read_ready[0]` high in cycle 2 with data 0xBEEF; channel 0 back to IDLE one cycle after valid drops.
- **Oversubscription:** 8 requesters read together, 4 channels, 3-cycle memory latency. Required: requesters 0-3 are served first on channels 0-3, then 4-7. Each requester gets `data = address + 0x100`. No requester is claimed twice.
- **Write (macro defined):** requester 5 writes 0x00AA to 0x40. Required: `mem_write_address` 0x40 and data 0x00AA on channel 0 until `mem_write_ready`; then `consumer_write_ready[5]` is asserted.
- **Simultaneous read and write from one requester:** read is serviced first. With the macro undefined, the write is never acknowledged and all `mem_write_valid` stay 0.
- **Reset mid-operation:** assert reset while channel 2 is in READ_WAIT. Required: all outputs 0 immediately. A late `mem_read_ready[2]` after reset produces no `consumer_read_ready`.
- **Slow requester:** the requester holds valid 5 cycles after ready. Required: ready stays high for those 5 cycles and the channel stays claimed, with no new claim on that channel until the edge after valid drops.
